wave_gen: RTL and testbench

WAVE_GEN -- requirements
Module: wave_gen

---
 rtl/wave_pkg.sv | 24 ++
 rtl/wave_lut.sv | 54 +++++
 rtl/wave_gen.sv | 194 +++++++++++++++++++
 tb/tb_wave_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the waveform generator: waveform mode encodings,
// default parameter widths and the constant used to build the sine table.
// No ports (package).
// -----------------------------------------------------------------------------
package wave_pkg;

  typedef enum logic [1:0] {
    MODE_TRI = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_SIN = 2'd3
  } wave_mode_e;

  localparam int ACC_W_DEF   = 24;
  localparam int FREQ_W_DEF  = 16;
  localparam int DAC_W_DEF   = 14;
  localparam int LUT_AW_DEF  = 10;
  localparam int PHASE_W_DEF = 8;

  localparam real SINE_PI = 3.14159265358979323846;

endpackage

// File: rtl/wave_lut.sv
// -----------------------------------------------------------------------------
// wave_lut
// Registered quarter-wave sine ROM. Only the first quadrant's magnitudes are
// stored; the other three quadrants are produced by mirroring the address and
// complementing the magnitude. Output is offset-binary, one clock of latency.
//
// Ports:
//   clk     in   clock, rising edge
//   i_addr  in   LUT_AW-bit phase
//   o_data  out  DAC_W-bit offset-binary sine sample (registered)
// -----------------------------------------------------------------------------
module wave_lut
  import wave_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int DAC_W  = DAC_W_DEF
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [DAC_W-1:0]  o_data
);

  localparam int  QAW    = LUT_AW - 2;
  localparam int  QDEPTH = 1 << QAW;
  localparam int  MAG_W  = DAC_W - 1;
  localparam real HALF   = real'((1 << MAG_W) - 1);

  // Samples sit at half-step offsets so the quadrant mirrors line up exactly
  // and no entry has to be shared between two quadrants.
  logic [MAG_W-1:0] w_rom [QDEPTH];

  genvar gi;
  for (gi = 0; gi < QDEPTH; gi++) begin : g_rom
    localparam real ANG = 2.0 * SINE_PI * (real'(gi) + 0.5) / real'(1 << LUT_AW);
    localparam int  MAG = $rtoi(HALF * $sin(ANG) + 0.5);
    assign w_rom[gi] = MAG_W'(MAG);
  end

  logic             w_neg;
  logic [QAW-1:0]   w_idx;
  logic [DAC_W-1:0] r_data;

  assign w_neg = i_addr[LUT_AW-1];
  assign w_idx = i_addr[LUT_AW-2] ? ~i_addr[QAW-1:0] : i_addr[QAW-1:0];

  // Positive half: mid + mag. Negative half: {0, ~mag} = mid - 1 - mag,
  // which keeps the wave symmetric about mid - 0.5.
  always_ff @(posedge clk) begin
    r_data <= w_neg ? {1'b0, ~w_rom[w_idx]} : {1'b1, w_rom[w_idx]};
  end

  assign o_data = r_data;

endmodule

// File: rtl/wave_gen.sv
// -----------------------------------------------------------------------------
// wave_gen
// DDS waveform generator: phase accumulator, 3-stage shaping pipeline
// (phase add -> shape / sine ROM -> attenuate) and a shadow/active config
// pair that only switches at an accumulator wrap (or at once when disabled).
// Assumes DAC_W >= LUT_AW, FREQ_W <= ACC_W, PHASE_W <= LUT_AW.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   run enable; low clears phase and forces midscale
//   cfg_load   in   strobe: capture cfg_* into the shadow config
//   cfg_freq   in   tuning word added to the accumulator each clock
//   cfg_amp    in   attenuation shift (gain 2^-cfg_amp)
//   cfg_phase  in   phase offset, MSB-aligned to the LUT address
//   cfg_mode   in   0 tri, 1 saw, 2 square, 3 sine
//   cfg_busy   out  shadow config waiting to be applied
//   dac_out    out  registered offset-binary sample
//   wrap       out  one-cycle pulse on accumulator overflow
// -----------------------------------------------------------------------------
module wave_gen
  import wave_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DAC_W   = DAC_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [FREQ_W-1:0]  cfg_freq,
  input  logic [2:0]         cfg_amp,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_busy,
  output logic [DAC_W-1:0]   dac_out,
  output logic               wrap
);

  localparam int               M     = DAC_W - 1;
  localparam int               SHIFT = DAC_W - LUT_AW;
  localparam logic [DAC_W-1:0] MID   = {1'b1, {(DAC_W-1){1'b0}}};

  // ---------------- configuration and accumulator ----------------
  logic [FREQ_W-1:0]  r_sh_freq, r_act_freq;
  logic [2:0]         r_sh_amp, r_act_amp;
  logic [PHASE_W-1:0] r_sh_phase, r_act_phase;
  wave_mode_e         r_sh_mode, r_act_mode;
  logic               r_busy;
  logic [ACC_W-1:0]   r_acc;
  logic               r_wrap;

  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic               w_apply;

  assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_act_freq);
  assign w_carry = en & w_sum[ACC_W];
  // A disabled generator has no period to protect, so apply right away.
  assign w_apply = r_busy & (w_carry | ~en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_wrap      <= 1'b0;
      r_busy      <= 1'b0;
      r_sh_freq   <= '0;
      r_sh_amp    <= '0;
      r_sh_phase  <= '0;
      r_sh_mode   <= MODE_TRI;
      r_act_freq  <= '0;
      r_act_amp   <= '0;
      r_act_phase <= '0;
      r_act_mode  <= MODE_TRI;
    end else begin
      r_acc  <= en ? w_sum[ACC_W-1:0] : '0;
      r_wrap <= w_carry;
      if (w_apply) begin
        r_act_freq  <= r_sh_freq;
        r_act_amp   <= r_sh_amp;
        r_act_phase <= r_sh_phase;
        r_act_mode  <= r_sh_mode;
      end
      // A load in the apply cycle refills the shadow after the old value
      // has moved to active, so busy stays set for the new one.
      if (cfg_load) begin
        r_sh_freq  <= cfg_freq;
        r_sh_amp   <= cfg_amp;
        r_sh_phase <= cfg_phase;
        r_sh_mode  <= wave_mode_e'(cfg_mode);
        r_busy     <= 1'b1;
      end else if (w_apply) begin
        r_busy <= 1'b0;
      end
    end
  end

  // ---------------- stage 1: phase ----------------
  logic [LUT_AW-1:0] w_phase_off;
  logic [LUT_AW-1:0] r_phase1;
  wave_mode_e        r_mode1;
  logic [2:0]        r_amp1;
  logic              r_v1;

  assign w_phase_off = LUT_AW'(r_act_phase) << (LUT_AW - PHASE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase1 <= '0;
      r_mode1  <= MODE_TRI;
      r_amp1   <= '0;
      r_v1     <= 1'b0;
    end else begin
      r_phase1 <= r_acc[ACC_W-1 -: LUT_AW] + w_phase_off;
      r_mode1  <= r_act_mode;
      r_amp1   <= r_act_amp;
      r_v1     <= en;
    end
  end

  // ---------------- stage 2: shape ----------------
  logic [DAC_W-1:0] w_saw, w_tri, w_sqr, w_shape, w_lut;
  logic [M-1:0]     w_ramp, w_tri_half;
  logic [DAC_W-1:0] r_shape2;
  logic             r_sin2;
  logic [2:0]       r_amp2;
  logic             r_v2;

  assign w_saw      = DAC_W'(r_phase1) << SHIFT;
  assign w_ramp     = M'(r_phase1[LUT_AW-2:0]) << SHIFT;
  assign w_tri_half = r_phase1[LUT_AW-1] ? ~w_ramp : w_ramp;
  // Repeating the top bit as the LSB stretches the triangle to full scale.
  assign w_tri      = {w_tri_half, w_tri_half[M-1]};
  assign w_sqr      = r_phase1[LUT_AW-1] ? '0 : '1;

  always_comb begin
    w_shape = w_saw;
    case (r_mode1)
      MODE_TRI: w_shape = w_tri;
      MODE_SQR: w_shape = w_sqr;
      default:  w_shape = w_saw;
    endcase
  end

  wave_lut #(
    .LUT_AW (LUT_AW),
    .DAC_W  (DAC_W)
  ) u_lut (
    .clk    (clk),
    .i_addr (r_phase1),
    .o_data (w_lut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shape2 <= '0;
      r_sin2   <= 1'b0;
      r_amp2   <= '0;
      r_v2     <= 1'b0;
    end else begin
      r_shape2 <= w_shape;
      r_sin2   <= (r_mode1 == MODE_SIN);
      r_amp2   <= r_amp1;
      r_v2     <= r_v1;
    end
  end

  // ---------------- stage 3: attenuate ----------------
  // Offset-binary minus mid is just the MSB flipped; shifting that signed
  // value and flipping back gives mid + ((s - mid) >>> amp).
  logic [DAC_W-1:0]        w_sample;
  logic signed [DAC_W-1:0] w_centered, w_scaled;
  logic [DAC_W-1:0]        r_dac;

  assign w_sample   = r_sin2 ? w_lut : r_shape2;
  assign w_centered = {~w_sample[DAC_W-1], w_sample[DAC_W-2:0]};
  assign w_scaled   = w_centered >>> r_amp2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dac <= MID;
    end else begin
      r_dac <= r_v2 ? {~w_scaled[DAC_W-1], w_scaled[DAC_W-2:0]} : MID;
    end
  end

  assign cfg_busy = r_busy;
  assign wrap     = r_wrap;
  assign dac_out  = r_dac;

endmodule

// File: tb/tb_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_wave_gen
// Scoreboard bench for wave_gen. The driver applies one input vector per
// clock and pushes the expected outputs from a behavioural model; a monitor
// pops one record per clock and compares. Directed windows also check the
// sawtooth period/step and the attenuated triangle extremes.
// -----------------------------------------------------------------------------
module tb_wave_gen;

  localparam int     MID     = 8192;
  localparam longint ACC_MOD = 64'd1 << 24;
  localparam real    PI      = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst, en, cfg_load;
  logic [15:0] cfg_freq;
  logic [2:0]  cfg_amp;
  logic [7:0]  cfg_phase;
  logic [1:0]  cfg_mode;
  logic        cfg_busy;
  logic [13:0] dac_out;
  logic        wrap;

  always #5 clk = ~clk;

  wave_gen #(
    .ACC_W(24), .FREQ_W(16), .DAC_W(14), .LUT_AW(10), .PHASE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
    .cfg_freq(cfg_freq), .cfg_amp(cfg_amp), .cfg_phase(cfg_phase),
    .cfg_mode(cfg_mode), .cfg_busy(cfg_busy), .dac_out(dac_out), .wrap(wrap)
  );

  typedef struct { int freq; int amp; int phase; int mode; } cfg_t;
  typedef struct { int dac; bit wrap; bit busy; } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   drv_cyc = 0;

  // behavioural model state
  longint m_acc;
  cfg_t   m_act, m_sh;
  bit     m_busy;
  int     m_p1, m_p2;

  // directed-window state
  bit saw_win = 0;
  bit tri_win = 0;
  int tri_max = -1;
  int tri_min = 1 << 20;

  // Waveform value at LUT phase p (0..1023), 14-bit offset binary.
  function automatic int ref_shape(int p, int mode);
    int  t, a, mag;
    real ang;
    case (mode)
      0: begin
        if (p < 512) t = p * 16;
        else         t = 8191 - (p - 512) * 16;
        return 2 * t + ((t >= 4096) ? 1 : 0);
      end
      1: return p * 16;
      2: return (p < 512) ? 16383 : 0;
      default: begin
        a = p % 512;
        if (a >= 256) a = 511 - a;
        ang = 2.0 * PI * (real'(a) + 0.5) / 1024.0;
        mag = $rtoi(8191.0 * $sin(ang) + 0.5);
        return (p < 512) ? 8192 + mag : 8191 - mag;
      end
    endcase
  endfunction

  function automatic int ref_sample(longint acc, cfg_t c);
    int p, d;
    p = (int'(acc >> 14) + c.phase * 4) % 1024;
    d = ref_shape(p, c.mode) - MID;
    d = d >>> c.amp;
    return MID + d;
  endfunction

  // Apply one vector for the next rising edge and push what should be
  // visible just after that edge.
  task automatic step(input bit r, input bit e, input bit ld, input cfg_t c);
    exp_t   x;
    int     s;
    longint sum;
    bit     carry, apply;
    rst = r; en = e; cfg_load = ld;
    cfg_freq = 16'(c.freq); cfg_amp = 3'(c.amp);
    cfg_phase = 8'(c.phase); cfg_mode = 2'(c.mode);
    if (ld)
      $display("load cyc=%0d rst=%0d en=%0d freq=%h amp=%0d phase=%h mode=%0d",
               drv_cyc, r, e, c.freq, c.amp, c.phase, c.mode);
    if (r) begin
      m_acc = 0; m_act = '{0, 0, 0, 0}; m_sh = '{0, 0, 0, 0}; m_busy = 0;
      m_p1 = MID; m_p2 = MID;
      x.dac = MID; x.wrap = 0; x.busy = 0;
    end else begin
      s = e ? ref_sample(m_acc, m_act) : MID;
      x.dac = m_p2; m_p2 = m_p1; m_p1 = s;
      sum   = m_acc + longint'(m_act.freq);
      carry = e && (sum >= ACC_MOD);
      apply = m_busy && (carry || !e);
      if (apply) m_act = m_sh;
      if (ld) begin m_sh = c; m_busy = 1; end
      else if (apply) m_busy = 0;
      m_acc = e ? (sum % ACC_MOD) : 0;
      x.wrap = carry; x.busy = m_busy;
    end
    exp_q.push_back(x);
    drv_cyc++;
    @(negedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t        x;
    logic [13:0] e_dac;
    int          mon_cyc = 0;
    int          last_wrap = -1;
    bit          prev_ok = 0;
    int          prev_dac = 0;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        e_dac = 14'(x.dac);
        n_vec++;
        if (dac_out !== e_dac) begin
          n_err++;
          $display("FAIL dac_out cyc=%0d got=%0d exp=%0d", mon_cyc, dac_out, e_dac);
        end
        if (wrap !== x.wrap) begin
          n_err++;
          $display("FAIL wrap cyc=%0d got=%0b exp=%0b", mon_cyc, wrap, x.wrap);
        end
        if (cfg_busy !== x.busy) begin
          n_err++;
          $display("FAIL cfg_busy cyc=%0d got=%0b exp=%0b", mon_cyc, cfg_busy, x.busy);
        end
      end
      if (saw_win) begin
        if (prev_ok) begin
          n_vec++;
          if (int'(dac_out) != (prev_dac + 16) % 16384) begin
            n_err++;
            $display("FAIL saw_step cyc=%0d got=%0d exp=%0d", mon_cyc, dac_out,
                     (prev_dac + 16) % 16384);
          end
        end
        prev_ok = 1; prev_dac = int'(dac_out);
        if (wrap === 1'b1) begin
          if (last_wrap >= 0) begin
            n_vec++;
            if (mon_cyc - last_wrap != 1024) begin
              n_err++;
              $display("FAIL saw_period cyc=%0d got=%0d exp=1024", mon_cyc, mon_cyc - last_wrap);
            end
          end
          last_wrap = mon_cyc;
        end
      end else begin
        prev_ok = 0; last_wrap = -1;
      end
      if (tri_win) begin
        if (int'(dac_out) > tri_max) tri_max = int'(dac_out);
        if (int'(dac_out) < tri_min) tri_min = int'(dac_out);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    cfg_t z, c;
    z = '{0, 0, 0, 0};

    // Reset with en high; a load during reset must be discarded.
    step(1, 1, 0, z);
    step(1, 1, 1, '{16'h4000, 3, 8'h10, 1});
    step(0, 1, 0, z);
    step(0, 1, 0, z);

    // Sawtooth, loaded while disabled so it applies at once.
    c = '{16'h4000, 0, 0, 1};
    step(0, 0, 1, c);
    repeat (4) step(0, 0, 0, z);
    repeat (10) step(0, 1, 0, z);
    saw_win = 1;
    repeat (2100) step(0, 1, 0, z);
    saw_win = 0;

    // Triangle at half amplitude, loaded mid-period (waits for the wrap).
    repeat (300) step(0, 1, 0, z);
    step(0, 1, 1, '{16'h4000, 1, 0, 0});
    repeat (1100) step(0, 1, 0, z);
    tri_win = 1;
    repeat (1030) step(0, 1, 0, z);
    tri_win = 0;
    n_vec++;
    if (tri_max != 12287) begin
      n_err++;
      $display("FAIL tri_peak got=%0d exp=12287", tri_max);
    end
    n_vec++;
    if (tri_min != 4096) begin
      n_err++;
      $display("FAIL tri_trough got=%0d exp=4096", tri_min);
    end

    // Back-to-back loads: only the second one may ever take effect.
    repeat (100) step(0, 1, 0, z);
    step(0, 1, 1, '{16'h1000, 2, 8'h00, 2});
    step(0, 1, 1, '{16'h8000, 0, 8'h40, 3});
    repeat (2100) step(0, 1, 0, z);

    // Enable drop / re-raise with a phase offset and a zero tuning word.
    repeat (5) step(0, 0, 0, z);
    step(0, 0, 1, '{0, 2, 8'h80, 1});
    repeat (4) step(0, 0, 0, z);
    repeat (20) step(0, 1, 0, z);
    step(0, 0, 1, '{16'h2345, 0, 8'h33, 3});
    repeat (3) step(0, 0, 0, z);
    repeat (300) step(0, 1, 0, z);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      c.freq  = int'($urandom_range(0, 65535));
      c.amp   = int'($urandom_range(0, 7));
      c.phase = int'($urandom_range(0, 255));
      c.mode  = int'($urandom_range(0, 3));
      step($urandom_range(0, 999) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 49) == 0, c);
    end

    // Drain the scoreboard.
    step(0, 0, 0, z);
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
